// File: rtl/vld_dp_ram_pipe.sv
// Single-clock two-port RAM with valid/ready handshakes, RD_LATENCY read pipeline,
// byte-enable writes and a zero-fill clear sequencer. Optional: VLD_DP_RAM_PIPE_COLL_DET_EN.
module vld_dp_ram_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 2,
    parameter bit WR_FIRST   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    output logic                      init_busy,
    input  logic                      addr_a_vld,
    input  logic                      addr_b_vld,
    input  logic                      wr_en_a,
    input  logic                      wr_en_b,
    input  logic [DATA_WIDTH/8-1:0]   be_a,
    input  logic [DATA_WIDTH/8-1:0]   be_b,
    input  logic [ADDR_WIDTH-1:0]     addr_a,
    input  logic [ADDR_WIDTH-1:0]     addr_b,
    input  logic [DATA_WIDTH-1:0]     din_a,
    input  logic [DATA_WIDTH-1:0]     din_b,
    output logic                      rdy_a,
    output logic                      rdy_b,
    output logic                      dout_a_vld,
    output logic                      dout_b_vld,
    output logic [DATA_WIDTH-1:0]     dout_a,
    output logic [DATA_WIDTH-1:0]     dout_b,
    output logic                      coll_err
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_a, wr_b;
    logic [1:0]            rd_acc;
    logic [DATA_WIDTH-1:0] rd_word [2];

    logic [RD_LATENCY-1:0] pipe_vld_q [2];
    logic [DATA_WIDTH-1:0] pipe_dat_q [2][RD_LATENCY];
    logic [1:0]            dout_vld_q;
    logic [DATA_WIDTH-1:0] dout_q [2];

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_W-1:0]       be
    );
        merge_bytes = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merge_bytes[i*8 +: 8] = new_w[i*8 +: 8];
        end
    endfunction

    assign init_busy = (state_q == ST_INIT);
    assign rdy_a     = ~init_busy;
    assign rdy_b     = ~init_busy;

    assign wr_a      = addr_a_vld & rdy_a & rst_n & wr_en_a;
    assign wr_b      = addr_b_vld & rdy_b & rst_n & wr_en_b;
    assign rd_acc[0] = addr_a_vld & rdy_a & rst_n & ~wr_en_a;
    assign rd_acc[1] = addr_b_vld & rdy_b & rst_n & ~wr_en_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: the array has no reset branch; the clear sequencer zero-fills it instead.
    // Port writes never overlap the sequencer (rdy is low in INIT); A is written last so it wins.
    always_ff @(posedge clk) begin
        if (init_busy) mem[cnt_q] <= '0;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_b && be_b[i]) mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
            if (wr_a && be_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
        end
    end

    always_comb begin
        rd_word[0] = mem[addr_a];
        rd_word[1] = mem[addr_b];
        if (WR_FIRST) begin
            if (wr_b && addr_b == addr_a) rd_word[0] = merge_bytes(rd_word[0], din_b, be_b);
            if (wr_a && addr_a == addr_b) rd_word[1] = merge_bytes(rd_word[1], din_a, be_a);
        end
    end

    // Valid stages and output registers are reset; data stages only ride along.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                pipe_vld_q[p] <= '0;
                dout_q[p]     <= '0;
            end
            dout_vld_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int s = RD_LATENCY - 1; s > 0; s--) begin
                    pipe_vld_q[p][s] <= pipe_vld_q[p][s-1];
                end
                pipe_vld_q[p][0] <= rd_acc[p];
                dout_vld_q[p]    <= pipe_vld_q[p][RD_LATENCY-1];
                if (pipe_vld_q[p][RD_LATENCY-1]) dout_q[p] <= pipe_dat_q[p][RD_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            for (int s = RD_LATENCY - 1; s > 0; s--) begin
                pipe_dat_q[p][s] <= pipe_dat_q[p][s-1];
            end
            if (rd_acc[p]) pipe_dat_q[p][0] <= rd_word[p];
        end
    end

    assign dout_a     = dout_q[0];
    assign dout_b     = dout_q[1];
    assign dout_a_vld = dout_vld_q[0];
    assign dout_b_vld = dout_vld_q[1];

`ifdef VLD_DP_RAM_PIPE_COLL_DET_EN
    logic coll_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= wr_a && wr_b && (addr_a == addr_b) && |(be_a & be_b);
        end
    end

    assign coll_err = coll_q;
`else
    assign coll_err = 1'b0;
`endif

endmodule

// File: tb/tb_vld_dp_ram_pipe.sv
// Scoreboard bench for vld_dp_ram_pipe (ADDR_WIDTH=4, RD_LATENCY=2); follows
// VLD_DP_RAM_PIPE_COLL_DET_EN for the expected coll_err behaviour.
module tb_vld_dp_ram_pipe;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LAT   = 2;
    localparam bit WRF   = 1'b0;
    localparam int DEPTH = 1 << AW;
`ifdef VLD_DP_RAM_PIPE_COLL_DET_EN
    localparam logic COLL_EN = 1'b1;
`else
    localparam logic COLL_EN = 1'b0;
`endif

    typedef struct {
        logic          vld;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [3:0]    be;
    } req_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          init_busy;
    logic          addr_a_vld, addr_b_vld;
    logic          wr_en_a, wr_en_b;
    logic [3:0]    be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;
    logic          rdy_a, rdy_b;
    logic          dout_a_vld, dout_b_vld;
    logic [DW-1:0] dout_a, dout_b;
    logic          coll_err;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] model [DEPTH];

    vld_dp_ram_pipe #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(LAT),
        .WR_FIRST  (WRF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .init_busy (init_busy),
        .addr_a_vld(addr_a_vld),
        .addr_b_vld(addr_b_vld),
        .wr_en_a   (wr_en_a),
        .wr_en_b   (wr_en_b),
        .be_a      (be_a),
        .be_b      (be_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .din_a     (din_a),
        .din_b     (din_b),
        .rdy_a     (rdy_a),
        .rdy_b     (rdy_b),
        .dout_a_vld(dout_a_vld),
        .dout_b_vld(dout_b_vld),
        .dout_a    (dout_a),
        .dout_b    (dout_b),
        .coll_err  (coll_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic req_t idle();
        req_t r;
        r.vld = 1'b0; r.wr = 1'b0; r.addr = '0; r.din = '0; r.be = '0;
        return r;
    endfunction

    function automatic req_t rd(input int addr);
        req_t r;
        r = idle();
        r.vld = 1'b1; r.addr = addr[AW-1:0];
        return r;
    endfunction

    function automatic req_t wr(input int addr, input logic [DW-1:0] d, input logic [3:0] be);
        req_t r;
        r = idle();
        r.vld = 1'b1; r.wr = 1'b1; r.addr = addr[AW-1:0]; r.din = d; r.be = be;
        return r;
    endfunction

    function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] w, input logic [DW-1:0] d,
                                               input logic [3:0] be);
        logic [DW-1:0] r;
        r = w;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic void zero_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    // Present one cycle of stimulus, record expected reads for accepted requests, advance.
    task automatic drive(input req_t a, input req_t b, input logic c);
        logic acc_a, acc_b;
        exp_t e;
        addr_a_vld = a.vld; wr_en_a = a.wr; addr_a = a.addr; din_a = a.din; be_a = a.be;
        addr_b_vld = b.vld; wr_en_b = b.wr; addr_b = b.addr; din_b = b.din; be_b = b.be;
        clr = c;
        acc_a = a.vld && rdy_a;
        acc_b = b.vld && rdy_b;
        if (acc_a && !a.wr) begin
            e.data = model[a.addr];
            if (WRF && acc_b && b.wr && b.addr == a.addr) e.data = apply_be(e.data, b.din, b.be);
            e.due = cyc + 1 + LAT;
            qa.push_back(e);
        end
        if (acc_b && !b.wr) begin
            e.data = model[b.addr];
            if (WRF && acc_a && a.wr && a.addr == b.addr) e.data = apply_be(e.data, a.din, a.be);
            e.due = cyc + 1 + LAT;
            qb.push_back(e);
        end
        if (acc_b && b.wr) model[b.addr] = apply_be(model[b.addr], b.din, b.be);
        if (acc_a && a.wr) model[a.addr] = apply_be(model[a.addr], a.din, a.be);
        if (c && !init_busy) zero_model();
        @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (dout_a_vld === 1'b1) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL rd_a_unexpected_vld cyc=%0d got=%h", cyc, dout_a);
                end else begin
                    e = qa.pop_front();
                    if (dout_a !== e.data || cyc != e.due) begin
                        failures++;
                        $display("FAIL rd_a got=%h@%0d exp=%h@%0d", dout_a, cyc, e.data, e.due);
                    end
                end
            end
            if (dout_b_vld === 1'b1) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL rd_b_unexpected_vld cyc=%0d got=%h", cyc, dout_b);
                end else begin
                    e = qb.pop_front();
                    if (dout_b !== e.data || cyc != e.due) begin
                        failures++;
                        $display("FAIL rd_b got=%h@%0d exp=%h@%0d", dout_b, cyc, e.data, e.due);
                    end
                end
            end
            while (qa.size() > 0 && qa[0].due < cyc) begin
                e = qa.pop_front();
                checks++; failures++;
                $display("FAIL rd_a_missing_vld cyc=%0d exp=%h due=%0d", cyc, e.data, e.due);
            end
            while (qb.size() > 0 && qb[0].due < cyc) begin
                e = qb.pop_front();
                checks++; failures++;
                $display("FAIL rd_b_missing_vld cyc=%0d exp=%h due=%0d", cyc, e.data, e.due);
            end
        end
    endtask

    task automatic drain(input string tag);
        repeat (LAT + 2) drive(idle(), idle(), 1'b0);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending_a=%0d pending_b=%0d exp=0", tag, qa.size(), qb.size());
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (init_busy && n < 40) begin
            n++;
            drive(idle(), idle(), 1'b0);
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        zero_model();
        drive(idle(), idle(), 1'b0);
        checks++;
        if ({init_busy, rdy_a, rdy_b, dout_a_vld, dout_b_vld, coll_err} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100000",
                     {init_busy, rdy_a, rdy_b, dout_a_vld, dout_b_vld, coll_err});
        end
        checks++;
        if ({dout_a, dout_b} !== '0) begin
            failures++;
            $display("FAIL reset_dout got=%h/%h exp=0/0", dout_a, dout_b);
        end
        drive(idle(), idle(), 1'b0);
        rst_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL reset_clear_cycles got=%0d exp=%0d", n, DEPTH);
        end
        checks++;
        if ({rdy_a, rdy_b} !== 2'b11) begin
            failures++;
            $display("FAIL reset_rdy got=%b exp=11", {rdy_a, rdy_b});
        end
        for (int i = 0; i < DEPTH; i++) drive(rd(i), idle(), 1'b0);
        drain("reset");
    endtask

    task automatic test_byte_en();
        drive(wr(3, 32'hAABBCCDD, 4'b1111), idle(), 1'b0);
        drive(wr(3, 32'h11223344, 4'b0101), idle(), 1'b0);
        drive(idle(), rd(3), 1'b0);
        drain("byte_en");
        checks++;
        if (dout_b !== 32'hAA22CC44) begin
            failures++;
            $display("FAIL byte_en got=%h exp=aa22cc44", dout_b);
        end
    endtask

    task automatic test_collision();
        drive(wr(5, 32'h000000FF, 4'b0001), wr(5, 32'h12345678, 4'b1111), 1'b0);
        checks++;
        if (coll_err !== COLL_EN) begin
            failures++;
            $display("FAIL coll_pulse got=%b exp=%b", coll_err, COLL_EN);
        end
        drive(idle(), idle(), 1'b0);
        checks++;
        if (coll_err !== 1'b0) begin
            failures++;
            $display("FAIL coll_clear got=%b exp=0", coll_err);
        end
        drive(wr(6, 32'h0000FF00, 4'b0010), wr(6, 32'h00FF0000, 4'b0100), 1'b0);
        checks++;
        if (coll_err !== 1'b0) begin
            failures++;
            $display("FAIL coll_disjoint_be got=%b exp=0", coll_err);
        end
        drive(rd(5), rd(6), 1'b0);
        drain("collision");
        checks++;
        if (dout_a !== 32'h123456FF) begin
            failures++;
            $display("FAIL coll_merge got=%h exp=123456ff", dout_a);
        end
    endtask

    task automatic test_cross_port();
        drive(wr(7, 32'h1, 4'b1111), idle(), 1'b0);
        drive(wr(7, 32'h2, 4'b1111), rd(7), 1'b0);
        drain("cross_b");
        checks++;
        if (dout_b !== (WRF ? 32'h2 : 32'h1)) begin
            failures++;
            $display("FAIL cross_b got=%h exp=%h", dout_b, (WRF ? 32'h2 : 32'h1));
        end
        drive(rd(7), wr(7, 32'h3, 4'b1111), 1'b0);
        drain("cross_a");
        checks++;
        if (dout_a !== (WRF ? 32'h3 : 32'h2)) begin
            failures++;
            $display("FAIL cross_a got=%h exp=%h", dout_a, (WRF ? 32'h3 : 32'h2));
        end
    endtask

    task automatic test_mid_run_clear();
        int n, rdy_hi;
        for (int i = 8; i < 12; i++) drive(wr(i, 32'hC0DE0000 | i, 4'b1111), idle(), 1'b0);
        for (int i = 8; i < 12; i++) drive(idle(), rd(i), 1'b0);
        drive(idle(), idle(), 1'b1);
        n = 0;
        rdy_hi = 0;
        // B keeps a read pending and a second clr is pulsed while clearing.
        while (init_busy && n < 40) begin
            n++;
            if (rdy_b !== 1'b0) rdy_hi++;
            drive(idle(), rd(0), n == 5);
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL clr_cycles got=%0d exp=%0d", n, DEPTH);
        end
        checks++;
        if (rdy_hi != 0) begin
            failures++;
            $display("FAIL clr_rdy_b_high got=%0d exp=0", rdy_hi);
        end
        drive(idle(), rd(0), 1'b0);
        for (int i = 0; i < DEPTH; i++) drive(rd(i), rd(DEPTH - 1 - i), 1'b0);
        drain("mid_clear");
    endtask

    task automatic test_reset_mid_init();
        int n;
        for (int i = 12; i < 16; i += 2) drive(wr(i, 32'hDEAD0000 | i, 4'b1111),
                                                wr(i + 1, 32'hBEEF0000 | i, 4'b1111), 1'b0);
        drive(idle(), idle(), 1'b1);
        repeat (9) drive(idle(), idle(), 1'b0);
        rst_n = 1'b0;
        drive(idle(), idle(), 1'b0);
        checks++;
        if ({init_busy, rdy_a, dout_a_vld, dout_b_vld} !== 4'b1000) begin
            failures++;
            $display("FAIL mid_init_reset got=%b exp=1000",
                     {init_busy, rdy_a, dout_a_vld, dout_b_vld});
        end
        rst_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL mid_init_cycles got=%0d exp=%0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) drive(rd(i), rd(i), 1'b0);
        drain("mid_init");
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        addr_a_vld = 1'b0; wr_en_a = 1'b0; be_a = '0; addr_a = '0; din_a = '0;
        addr_b_vld = 1'b0; wr_en_b = 1'b0; be_b = '0; addr_b = '0; din_b = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_byte_en();
        test_collision();
        test_cross_port();
        test_mid_run_clear();
        test_reset_mid_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
